// File: rtl/blake2_msg_ctrl_pkg.sv
// Shared constants for the BLAKE2 message sequencer: IV table, block size,
// FSM state encodings and the parameter-block initial chaining value.
package blake2_msg_ctrl_pkg;

  localparam int BLK_WORDS = 16;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // BLAKE2s IV words are the upper halves of the BLAKE2b IV words.
  localparam logic [7:0][63:0] IV64 = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  function automatic logic [7:0][63:0] h_init(input int w, input int nn);
    logic [7:0][63:0] h;
    for (int i = 0; i < 8; i++)
      h[i] = (w == 64) ? IV64[i] : {32'h0, IV64[i][63:32]};
    h[0] = h[0] ^ 64'h0101_0000 ^ 64'(nn);
    return h;
  endfunction

endpackage

// File: rtl/blake2_msg_ctrl_if.sv
// Byte-counted message word stream from the host into the sequencer.
interface blake2_msg_ctrl_if #(parameter int W = 64) ();
  localparam int BW = $clog2(W/8) + 1;

  logic          data_valid;
  logic          data_ready;
  logic [W-1:0]  data;
  logic          data_last;
  logic [BW-1:0] data_bytes;

  modport master (output data_valid, data, data_last, data_bytes, input data_ready);
  modport slave  (input data_valid, data, data_last, data_bytes, output data_ready);
endinterface

// File: rtl/blake2_msg_ctrl_blk_buf.sv
// 16-word message block buffer with write pointer, tail byte masking and clear.
// blk_nxt_o shows the contents including this cycle's write.
module blake2_msg_ctrl_blk_buf
  import blake2_msg_ctrl_pkg::*;
#(
  parameter int W  = 64,
  parameter int BW = $clog2(W/8) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic              last_i,
  input  logic [BW-1:0]     bytes_i,
  input  logic [W-1:0]      data_i,
  output logic [3:0]        wptr_o,
  output logic [16*W-1:0]   blk_o,
  output logic [16*W-1:0]   blk_nxt_o
);

  logic [BLK_WORDS-1:0][W-1:0] mem_q, mem_d;
  logic [3:0]                  wptr_q, wptr_d;
  logic [W-1:0]                wdata;

  always_comb begin
    wdata = data_i;
    if (last_i) begin
      for (int k = 0; k < W/8; k++)
        if (k >= int'(bytes_i)) wdata[8*k +: 8] = 8'h00;
    end
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (clr_i) begin
      mem_d  = '0;
      wptr_d = '0;
    end else if (we_i) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
    end
  end

  assign wptr_o    = wptr_q;
  assign blk_o     = mem_q;
  assign blk_nxt_o = mem_d;

endmodule

// File: rtl/blake2_msg_ctrl.sv
// BLAKE2 message sequencer: packs the host stream into blocks, tracks t/f,
// runs one compression per block, chains h and presents the digest.
module blake2_msg_ctrl
  import blake2_msg_ctrl_pkg::*;
#(
  parameter int W  = 64,
  parameter int NN = 64
) (
  input  logic              clk,
  input  logic              reset,
  blake2_msg_ctrl_if.slave  data_if,
  output logic              cmp_start_o,
  output logic [8*W-1:0]    cmp_h_o,
  output logic [16*W-1:0]   cmp_m_o,
  output logic [2*W-1:0]    cmp_t_o,
  output logic              cmp_f_o,
  input  logic              cmp_done_i,
  input  logic [8*W-1:0]    cmp_h_i,
  output logic              hash_valid_o,
  output logic [8*W-1:0]    hash_o,
  input  logic              hash_ready_i
);

  localparam int TW = 2*W;
  localparam int BW = $clog2(W/8) + 1;
  localparam logic [7:0][63:0] HI64 = h_init(W, NN);

  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       t_q, t_d, t_inc;
  logic [7:0][W-1:0]   h_q, h_d, h_init_w;
  logic [8*W-1:0]      cmp_h_q;
  logic [16*W-1:0]     cmp_m_q, blk_nxt, blk_cur;
  logic [TW-1:0]       cmp_t_q;
  logic                cmp_f_q;
  logic                hs, ld_cmp, buf_clr;
  logic [3:0]          wcnt;

  always_comb begin
    for (int i = 0; i < 8; i++) h_init_w[i] = HI64[i][W-1:0];
  end

  assign data_if.data_ready = (state_q == ST_FILL);
  assign hs = data_if.data_valid && data_if.data_ready;

  blake2_msg_ctrl_blk_buf #(.W(W), .BW(BW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (buf_clr),
    .we_i      (hs),
    .last_i    (data_if.data_last),
    .bytes_i   (data_if.data_bytes),
    .data_i    (data_if.data),
    .wptr_o    (wcnt),
    .blk_o     (blk_cur),
    .blk_nxt_o (blk_nxt)
  );

  always_comb begin
    t_inc   = data_if.data_last ? TW'(data_if.data_bytes) : TW'(W/8);
    state_d = state_q;
    t_d     = t_q;
    h_d     = h_q;
    ld_cmp  = 1'b0;
    buf_clr = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (hs) begin
          t_d = t_q + t_inc;
          if (data_if.data_last || wcnt == 4'(BLK_WORDS-1)) begin
            state_d = ST_START;
            ld_cmp  = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cmp_done_i) begin
          h_d     = cmp_h_i;
          buf_clr = 1'b1;
          state_d = cmp_f_q ? ST_OUT : ST_FILL;
        end
      end
      ST_OUT: begin
        if (hash_ready_i) begin
          state_d = ST_FILL;
          h_d     = h_init_w;
          t_d     = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Core-facing block registers load on the edge that completes a block and
  // hold until the next block completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      t_q     <= '0;
      h_q     <= h_init_w;
      cmp_h_q <= '0;
      cmp_m_q <= '0;
      cmp_t_q <= '0;
      cmp_f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      h_q     <= h_d;
      if (ld_cmp) begin
        cmp_h_q <= h_q;
        cmp_m_q <= blk_nxt;
        cmp_t_q <= t_d;
        cmp_f_q <= data_if.data_last;
      end
    end
  end

  assign cmp_start_o  = (state_q == ST_START);
  assign cmp_h_o      = cmp_h_q;
  assign cmp_m_o      = cmp_m_q;
  assign cmp_t_o      = cmp_t_q;
  assign cmp_f_o      = cmp_f_q;
  assign hash_valid_o = (state_q == ST_OUT);
  assign hash_o       = hash_valid_o ? h_q : '0;

  // A zero byte count is only legal for the empty message.
  a_zero_bytes_only_empty : assert property (@(posedge clk) disable iff (reset)
    (hs && data_if.data_last && data_if.data_bytes == '0) |-> (wcnt == 4'd0));

  logic unused_blk;
  assign unused_blk = ^blk_cur;

endmodule
